serial_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one 6-bit parallel-to-serial converter between N_REQ word sources. It arbitrates between pending requests and latches the winner's word. It then drives the serializer's enable and parallel inputs for exactly one frame, and inserts a programmable idle gap before the next frame. It sits between the word producers and the serializer instance, and owns all sequencing of the serializer.

---
 rtl/serial_tx_pkg.sv | 22 ++
 rtl/serial_tx_scheduler_rr_pick.sv | 32 +++
 rtl/serial_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_serial_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial transmit scheduler.
// Combinational only: no latency and no backpressure.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int MAX_N_REQ = 8;
    localparam int MAX_GAP   = 15;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping at N_REQ-1.
// Purely combinational: zero latency, no backpressure.
module rr_pick
    import serial_tx_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int OW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    rr_ptr,
    output logic             vld,
    output logic [OW-1:0]    winner
);

    logic [OW:0] idx;

    // Walk offsets from the far end down so the smallest offset is the final assignment.
    always_comb begin
        vld    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (OW + 1)'(i);
            if (idx >= (OW + 1)'(N_REQ)) idx = idx - (OW + 1)'(N_REQ);
            if (req[idx[OW-1:0]]) begin
                vld    = 1'b1;
                winner = idx[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one WIDTH-bit serializer among N_REQ sources: arbitrate, load, shift, idle gap.
// Latency: req sampled at edge k -> gnt/ser_start in cycle k+1, frame_done in cycle k+1+WIDTH.
// Backpressure: sources hold req until gnt; while busy no request is sampled.
module serial_tx_scheduler
    import serial_tx_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 6,
    parameter  int GAP   = 1,
    localparam int OW    = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   abort,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       ser_word,
    output logic                   ser_start,
    output logic                   busy,
    output logic [OW-1:0]          owner,
    output logic                   frame_done
);

    localparam int              BW       = clog2(WIDTH + 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);
    localparam logic [OW-1:0]   OWN_LAST = OW'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [OW-1:0]     owner_d;
    logic [WIDTH-1:0]  word_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              start_d, busy_d, done_d;

    logic              pick_vld;
    logic [OW-1:0]     pick_idx;
    logic [WIDTH-1:0]  pick_word;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .vld    (pick_vld),
        .winner (pick_idx)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == OW'(i)) pick_word = data_in[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        owner_d   = owner;
        word_d    = ser_word;
        case (state_q)
            ST_IDLE: begin
                if (!abort && pick_vld) begin
                    owner_d = pick_idx;
                    word_d  = pick_word;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rr_ptr_d  = (owner == OWN_LAST) ? '0 : owner + OW'(1);
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort drops the frame but keeps any pointer advance made in LOAD.
        if (abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        start_d = (state_d == ST_LOAD);
        gnt_d   = start_d ? (N_REQ'(1) << owner_d) : '0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_SHIFT) && (bit_cnt_d == BIT_LAST);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            owner      <= '0;
            ser_word   <= '0;
            gnt        <= '0;
            ser_start  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            owner      <= owner_d;
            ser_word   <= word_d;
            gnt        <= gnt_d;
            ser_start  <= start_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed and randomized bench for serial_tx_scheduler against a frame-timeline model.
module tb_serial_tx_scheduler;

    localparam int N = 4;
    localparam int W = 6;
    localparam int G = 1;

    logic           clk = 1'b0;
    logic           clr_n;
    logic           abort;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   ser_word;
    logic           ser_start;
    logic           busy;
    logic [1:0]     owner;
    logic           frame_done;

    serial_tx_scheduler #(.N_REQ(N), .WIDTH(W), .GAP(G)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .abort      (abort),
        .req        (req),
        .data_in    (data_in),
        .gnt        (gnt),
        .ser_word   (ser_word),
        .ser_start  (ser_start),
        .busy       (busy),
        .owner      (owner),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a frame is a timeline measured from its grant cycle (phase 0).
    bit           m_busy;
    int           m_phase;
    int           m_owner;
    int           m_ptr;
    logic [W-1:0] m_word;

    int start_cyc[$];
    int start_own[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_phase = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_word  = '0;
    endtask

    task automatic model_edge();
        int j;
        if (!m_busy) begin
            if (!abort && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (req[j] && !m_busy) begin
                        m_busy  = 1'b1;
                        m_phase = 0;
                        m_owner = j;
                        m_word  = data_in[j*W +: W];
                    end
                end
            end
        end else begin
            if (m_phase == 0) m_ptr = (m_owner + 1) % N;
            if (abort) m_busy = 1'b0;
            else begin
                m_phase++;
                if (m_phase > W + G) m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        bit exp_start;
        exp_start = m_busy && (m_phase == 0);
        chk("gnt",        32'(gnt),        exp_start ? 32'(1 << m_owner) : 32'd0);
        chk("ser_start",  32'(ser_start),  32'(exp_start));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("frame_done", 32'(frame_done), 32'(m_busy && (m_phase == W)));
        chk("owner",      32'(owner),      32'(m_owner));
        chk("ser_word",   32'(ser_word),   32'(m_word));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
        if (ser_start) begin
            start_cyc.push_back(cyc);
            start_own.push_back(int'(owner));
        end
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        model_reset();
    endtask

    task automatic settle();
        req   = '0;
        abort = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask

    initial begin
        int exp_own[5];
        clr_n   = 1'b0;
        abort   = 1'b0;
        req     = '0;
        data_in = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt),        32'd0);
        chk("rst_start", 32'(ser_start),  32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);
        chk("rst_owner", 32'(owner),      32'd0);
        chk("rst_word",  32'(ser_word),   32'd0);
        clr_n = 1'b1;

        // Single frame from source 0.
        data_in[5:0] = 6'h2A;
        req = 4'b0001;
        step();
        chk("t1_gnt",   32'(gnt),       32'h1);
        chk("t1_start", 32'(ser_start), 32'd1);
        req = '0;
        for (int i = 1; i <= W; i++) begin
            step();
            chk("t1_word", 32'(ser_word),   32'h2A);
            chk("t1_done", 32'(frame_done), 32'(i == W));
        end
        step();
        chk("t1_gap_busy", 32'(busy), 32'd1);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // All sources requesting: rotation and frame spacing.
        do_reset();
        for (int i = 0; i < N; i++) data_in[i*W +: W] = W'($urandom);
        start_cyc.delete();
        start_own.delete();
        req = 4'b1111;
        for (int i = 0; i < 40; i++) step();
        exp_own = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(start_cyc.size()), 32'd5);
        for (int i = 0; i < 5 && i < start_own.size(); i++)
            chk("rr_owner", 32'(start_own[i]), 32'(exp_own[i]));
        for (int i = 1; i < start_cyc.size(); i++)
            chk("rr_period", 32'(start_cyc[i] - start_cyc[i-1]), 32'(2 + W + G));
        settle();

        // Wrap-around from rr_ptr=2.
        do_reset();
        req = 4'b0010;
        step();
        chk("wrap_first", 32'(owner), 32'd1);
        req = '0;
        for (int i = 0; i < 9; i++) step();
        req = 4'b0011;
        step();
        chk("wrap_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 9; i++) step();
        chk("wrap_next_start", 32'(ser_start), 32'd1);
        chk("wrap_next_owner", 32'(owner),     32'd1);
        settle();

        // Abort on the third SHIFT cycle with another request pending.
        req = 4'b0001;
        step();
        req = 4'b0010;
        for (int i = 0; i < 3; i++) step();
        abort = 1'b1;
        step();
        chk("abort_busy", 32'(busy),       32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        abort = 1'b0;
        step();
        chk("abort_regrant", 32'(gnt), 32'h2);
        settle();

        // Asynchronous reset mid-SHIFT.
        req = 4'b1111;
        step();
        for (int i = 0; i < 3; i++) step();
        #3;
        clr_n = 1'b0;
        #1;
        chk("arst_gnt",   32'(gnt),        32'd0);
        chk("arst_start", 32'(ser_start),  32'd0);
        chk("arst_busy",  32'(busy),       32'd0);
        chk("arst_done",  32'(frame_done), 32'd0);
        chk("arst_owner", 32'(owner),      32'd0);
        chk("arst_word",  32'(ser_word),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_busy", 32'(busy), 32'd0);
        clr_n = 1'b1;
        step();
        chk("arst_after_gnt", 32'(gnt), 32'h1);
        settle();

        // Request pulse between edges is never seen.
        #1;
        req = 4'b0100;
        #2;
        req = '0;
        step();
        chk("glitch_gnt",  32'(gnt),  32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);
        step();
        chk("glitch_busy2", 32'(busy), 32'd0);

        // Randomized traffic with occasional aborts.
        for (int i = 0; i < 400; i++) begin
            req   = N'($urandom);
            abort = ($urandom_range(0, 19) == 0);
            for (int s = 0; s < N; s++) data_in[s*W +: W] = W'($urandom);
            step();
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
